// File: rtl/sc_loadscheduler_pkg.sv
// Shared types and constants for the load/clear/shift sequencing controller.
package sc_loadscheduler_pkg;

  localparam int unsigned TickDivDefault = 8;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StClearPulse = 3'd1,
    StClearWait  = 3'd2,
    StLoadPulse  = 3'd3,
    StLoadWait   = 3'd4,
    StShiftPulse = 3'd5
  } state_e;

endpackage

// File: rtl/sc_tickdivider.sv
// Scroll tick divider: free-running counter, one-deep pending tick and sticky loss flag.
module sc_tickdivider #(
  parameter int unsigned TickDiv = 8,
  parameter int unsigned Cw      = $clog2(TickDiv)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic consume_i,
  input  logic clear_i,
  output logic pending_o,
  output logic tick_lost_o
);

  logic [Cw-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          lost_q, lost_d;
  logic          tc;

  assign tc = enable_i && (cnt_q == Cw'(TickDiv - 1));

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    lost_d    = lost_q;
    if (clear_i) begin
      cnt_d     = '0;
      pending_d = 1'b0;
      lost_d    = 1'b0;
    end else begin
      if (enable_i) begin
        cnt_d = tc ? '0 : cnt_q + Cw'(1);
      end
      // A tick landing on the consume edge refills pending instead of being lost.
      if (tc) begin
        pending_d = 1'b1;
        if (pending_q && !consume_i) begin
          lost_d = 1'b1;
        end
      end else if (consume_i) begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  assign pending_o   = pending_q;
  assign tick_lost_o = lost_q;

endmodule

// File: rtl/sc_loadscheduler.sv
// Merges clear/load requests and scroll ticks into exclusive one-cycle active-low strobes.
module sc_loadscheduler
  import sc_loadscheduler_pkg::*;
#(
  parameter  int unsigned TICK_DIV = TickDivDefault,
  localparam int unsigned CW       = $clog2(TICK_DIV)
) (
  input  logic SC_LOADSCHEDULER_CLOCK_50,
  input  logic SC_LOADSCHEDULER_RESET_InLow,
  input  logic SC_LOADSCHEDULER_clear_InLow,
  input  logic SC_LOADSCHEDULER_load_InLow,
  input  logic SC_LOADSCHEDULER_enable_InHigh,
  output logic SC_LOADSCHEDULER_clear_OutLow,
  output logic SC_LOADSCHEDULER_load_OutLow,
  output logic SC_LOADSCHEDULER_shift_OutLow,
  output logic SC_LOADSCHEDULER_busy_OutHigh,
  output logic SC_LOADSCHEDULER_tickLost_OutHigh
);

  state_e state_q, state_d;
  logic   pending;
  logic   consume;
  logic   clear_evt;

  sc_tickdivider #(
    .TickDiv(TICK_DIV),
    .Cw     (CW)
  ) u_tickdivider (
    .clk_i      (SC_LOADSCHEDULER_CLOCK_50),
    .rst_ni     (SC_LOADSCHEDULER_RESET_InLow),
    .enable_i   (SC_LOADSCHEDULER_enable_InHigh),
    .consume_i  (consume),
    .clear_i    (clear_evt),
    .pending_o  (pending),
    .tick_lost_o(SC_LOADSCHEDULER_tickLost_OutHigh)
  );

  always_ff @(posedge SC_LOADSCHEDULER_CLOCK_50 or negedge SC_LOADSCHEDULER_RESET_InLow) begin
    if (!SC_LOADSCHEDULER_RESET_InLow) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    consume   = 1'b0;
    clear_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!SC_LOADSCHEDULER_clear_InLow) begin
          state_d   = StClearPulse;
          clear_evt = 1'b1;
        end else if (!SC_LOADSCHEDULER_load_InLow) begin
          state_d = StLoadPulse;
        end else if (pending) begin
          state_d = StShiftPulse;
          consume = 1'b1;
        end
      end
      StClearPulse: state_d = StClearWait;
      StClearWait:  if (SC_LOADSCHEDULER_clear_InLow) state_d = StIdle;
      StLoadPulse:  state_d = StLoadWait;
      StLoadWait:   if (SC_LOADSCHEDULER_load_InLow) state_d = StIdle;
      StShiftPulse: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    SC_LOADSCHEDULER_clear_OutLow = (state_q != StClearPulse);
    SC_LOADSCHEDULER_load_OutLow  = (state_q != StLoadPulse);
    SC_LOADSCHEDULER_shift_OutLow = (state_q != StShiftPulse);
    SC_LOADSCHEDULER_busy_OutHigh = (state_q != StIdle);
  end

endmodule
